// File: rtl/ecg_gate_timer.sv
// ECG beat acceptance with refractory window and R-R interval measurement,
// driving a delayed, fixed-width gate pulse after every accepted beat.
module ecg_gate_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             edge_state,
  input  logic             edge_toggle,
  input  logic [CNT_W-1:0] refractory,
  input  logic [CNT_W-1:0] gate_delay,
  input  logic [CNT_W-1:0] gate_width,
  output logic             gate,
  output logic [CNT_W-1:0] rr_interval,
  output logic             rr_valid,
  output logic             missed_beat,
  output logic [7:0]       beat_count
);

  typedef enum logic [1:0] {IDLE, REFRACT, ARMED} acc_state_t;
  typedef enum logic [1:0] {G_IDLE, G_DELAY, G_ON} gate_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_tog_q;
  acc_state_t       r_acc_state, w_acc_next;
  gate_state_t      r_gate_state, w_gate_next;
  logic [CNT_W-1:0] r_ivl_cnt;
  logic [CNT_W-1:0] r_refr, r_gdelay, r_gwidth;
  logic [CNT_W-1:0] r_dcnt, w_dcnt_next;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_next;
  logic [CNT_W-1:0] r_rr_interval;
  logic             r_rr_valid, r_missed;
  logic [7:0]       r_beat_count;

  logic w_raw, w_timeout, w_accept, w_rr_load, w_miss;

  assign w_raw     = (edge_toggle != r_tog_q) & edge_state;
  assign w_timeout = (r_ivl_cnt == CNT_MAX);

  // A zero refractory skips REFRACT so the very next cycle can accept a beat.
  always_comb begin
    w_acc_next = r_acc_state;
    w_accept   = 1'b0;
    w_rr_load  = 1'b0;
    w_miss     = 1'b0;
    if (!enable) begin
      w_acc_next = IDLE;
    end else begin
      case (r_acc_state)
        IDLE: begin
          if (w_raw) begin
            w_accept   = 1'b1;
            w_acc_next = (refractory == '0) ? ARMED : REFRACT;
          end
        end
        REFRACT: begin
          if (w_timeout) begin
            w_miss     = 1'b1;
            w_acc_next = IDLE;
          end else if (r_ivl_cnt >= r_refr) begin
            w_acc_next = ARMED;
          end
        end
        ARMED: begin
          if (w_raw) begin
            w_accept   = 1'b1;
            w_rr_load  = 1'b1;
            w_acc_next = (refractory == '0) ? ARMED : REFRACT;
          end else if (w_timeout) begin
            w_miss     = 1'b1;
            w_acc_next = IDLE;
          end
        end
        default: w_acc_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_gate_next = r_gate_state;
    w_dcnt_next = r_dcnt;
    w_wcnt_next = r_wcnt;
    if (!enable) begin
      w_gate_next = G_IDLE;
    end else if (w_accept) begin
      if (gate_width == '0) begin
        w_gate_next = G_IDLE;
      end else if (gate_delay == '0) begin
        w_gate_next = G_ON;
        w_wcnt_next = CNT_ONE;
      end else begin
        w_gate_next = G_DELAY;
        w_dcnt_next = CNT_ONE;
      end
    end else begin
      case (r_gate_state)
        G_DELAY: begin
          if (r_dcnt >= r_gdelay) begin
            w_gate_next = G_ON;
            w_wcnt_next = CNT_ONE;
          end else begin
            w_dcnt_next = r_dcnt + CNT_ONE;
          end
        end
        G_ON: begin
          if (r_wcnt >= r_gwidth) begin
            w_gate_next = G_IDLE;
          end else begin
            w_wcnt_next = r_wcnt + CNT_ONE;
          end
        end
        default: w_gate_next = G_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_tog_q <= edge_toggle;
    if (rst) begin
      r_acc_state   <= IDLE;
      r_gate_state  <= G_IDLE;
      r_ivl_cnt     <= '0;
      r_refr        <= '0;
      r_gdelay      <= '0;
      r_gwidth      <= '0;
      r_dcnt        <= '0;
      r_wcnt        <= '0;
      r_rr_interval <= '0;
      r_rr_valid    <= 1'b0;
      r_missed      <= 1'b0;
      r_beat_count  <= '0;
    end else begin
      r_acc_state  <= w_acc_next;
      r_gate_state <= w_gate_next;
      r_dcnt       <= w_dcnt_next;
      r_wcnt       <= w_wcnt_next;
      r_rr_valid   <= w_rr_load;
      r_missed     <= w_miss;
      if (w_rr_load) begin
        r_rr_interval <= r_ivl_cnt;
      end
      if (w_accept) begin
        r_ivl_cnt    <= CNT_ONE;
        r_beat_count <= r_beat_count + 8'd1;
        r_refr       <= refractory;
        r_gdelay     <= gate_delay;
        r_gwidth     <= gate_width;
      end else if (enable && !w_timeout) begin
        r_ivl_cnt <= r_ivl_cnt + CNT_ONE;
      end
    end
  end

  assign gate        = (r_gate_state == G_ON);
  assign rr_interval = r_rr_interval;
  assign rr_valid    = r_rr_valid;
  assign missed_beat = r_missed;
  assign beat_count  = r_beat_count;

endmodule

// File: tb/tb_ecg_gate_timer.sv
// Scoreboard bench for ecg_gate_timer: a cycle-level beat/gate model pushes
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_ecg_gate_timer;
  localparam int unsigned CNT_W = 8;
  localparam int MAXV = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       edge_state = 1'b0;
  logic       edge_toggle = 1'b0;
  logic [7:0] refractory = '0;
  logic [7:0] gate_delay = '0;
  logic [7:0] gate_width = '0;
  logic       gate;
  logic [7:0] rr_interval;
  logic       rr_valid;
  logic       missed_beat;
  logic [7:0] beat_count;

  ecg_gate_timer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .edge_state(edge_state),
    .edge_toggle(edge_toggle), .refractory(refractory), .gate_delay(gate_delay),
    .gate_width(gate_width), .gate(gate), .rr_interval(rr_interval),
    .rr_valid(rr_valid), .missed_beat(missed_beat), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; bit is_miss; int ivl; int bc; } ev_t;
  typedef struct { int due; bit g; } gexp_t;
  typedef struct { int due; int rr; int bc; } snap_t;
  ev_t   ev_q[$];
  gexp_t g_q[$];
  snap_t s_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: beats are tracked by absolute cycle number.
  bit     m_active = 0;
  int     m_last = 0;
  int     m_R = 0;
  int     g_start = 0;
  int     g_end = 0;
  int     m_bc = 0;
  int     m_rr = 0;
  bit     m_tog_prev = 0;
  int     p_refr = 0, p_del = 0, p_wid = 0;

  task automatic step(input bit r, input bit en, input bit flip, input bit es);
    bit raw, acc, rrv;
    int c, ivl, arm;
    @(posedge clk);
    #1;
    c = cyc;
    rst = r;
    enable = en;
    edge_state = es;
    refractory = 8'(p_refr);
    gate_delay = 8'(p_del);
    gate_width = 8'(p_wid);
    if (flip) edge_toggle = ~edge_toggle;
    raw = (edge_toggle != m_tog_prev) && es;
    m_tog_prev = edge_toggle;
    g_q.push_back('{c, (c >= g_start && c < g_end)});
    acc = 0;
    rrv = 0;
    if (r) begin
      m_active = 0;
      m_bc = 0;
      m_rr = 0;
      if (g_end > c + 1) g_end = c + 1;
      s_q.push_back('{c + 1, 0, 0});
    end else if (!en) begin
      m_active = 0;
      if (g_end > c + 1) g_end = c + 1;
    end else begin
      ivl = c - m_last;
      if (!m_active) begin
        acc = raw;
      end else begin
        arm = (m_R == 0) ? m_last + 1 : m_last + m_R + 1;
        if (raw && c >= arm) begin
          acc = 1;
          rrv = 1;
        end else if (ivl >= MAXV) begin
          m_active = 0;
          ev_q.push_back('{c + 1, 1, m_rr, m_bc});
        end
      end
      if (acc) begin
        m_bc = (m_bc + 1) % 256;
        if (rrv) begin
          m_rr = ivl;
          ev_q.push_back('{c + 1, 0, ivl, m_bc});
        end
        m_active = 1;
        m_last = c;
        m_R = p_refr;
        g_start = c + 1 + p_del;
        g_end = g_start + p_wid;
      end
    end
  endtask

  task automatic beat();
    step(0, 1, 1, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic set_p(input int r, input int d, input int w);
    p_refr = r;
    p_del = d;
    p_wid = w;
  endtask

  always @(negedge clk) begin
    gexp_t g;
    snap_t s;
    ev_t e;
    if (g_q.size() > 0 && g_q[0].due == cyc) begin
      g = g_q.pop_front();
      checks++;
      if (gate !== g.g) begin
        errors++;
        $display("FAIL gate@%0d: got %b expected %b", cyc, gate, g.g);
      end
    end
    if (s_q.size() > 0 && s_q[0].due == cyc) begin
      s = s_q.pop_front();
      checks++;
      if (rr_interval !== 8'(s.rr) || beat_count !== 8'(s.bc) || rr_valid !== 1'b0 || missed_beat !== 1'b0) begin
        errors++;
        $display("FAIL reset_state@%0d: got rr=%0d bc=%0d rv=%b mb=%b expected rr=%0d bc=%0d rv=0 mb=0",
                 cyc, rr_interval, beat_count, rr_valid, missed_beat, s.rr, s.bc);
      end
    end
    if (rr_valid === 1'b1 || missed_beat === 1'b1) begin
      checks++;
      if (ev_q.size() == 0) begin
        errors++;
        $display("FAIL strobe@%0d: got rv=%b mb=%b rr=%0d, expected no strobe", cyc, rr_valid, missed_beat, rr_interval);
      end else begin
        e = ev_q.pop_front();
        if (e.due != cyc || rr_valid !== !e.is_miss || missed_beat !== e.is_miss ||
            rr_interval !== 8'(e.ivl) || beat_count !== 8'(e.bc)) begin
          errors++;
          $display("FAIL strobe@%0d: got rv=%b mb=%b rr=%0d bc=%0d expected due=%0d mb=%b rr=%0d bc=%0d",
                   cyc, rr_valid, missed_beat, rr_interval, beat_count, e.due, e.is_miss, e.ivl, e.bc);
        end
      end
    end
    while (ev_q.size() > 0 && ev_q[0].due < cyc) begin
      e = ev_q.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe_absent: got none expected at cycle %0d mb=%b rr=%0d", e.due, e.is_miss, e.ivl);
    end
  end

  initial begin
    set_p(10, 3, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    idle(5);
    // refractory 10, delay 3, width 4, beats 200 apart
    beat(); idle(199); beat(); idle(20);
    idle(260);
    // beat inside refractory ignored, then timeout and unarmed beat
    set_p(50, 3, 4);
    beat(); idle(29); beat(); idle(69); beat(); idle(300);
    beat(); idle(10);
    idle(260);
    // zero delay retrigger keeps gate continuously high
    set_p(5, 0, 20);
    beat(); idle(9); beat(); idle(30);
    // timeout coinciding with a beat in ARMED
    set_p(5, 2, 3);
    beat(); idle(254); beat(); idle(5);
    // zero width, retrigger with nonzero delay
    set_p(5, 6, 0);
    beat(); idle(10);
    set_p(5, 6, 10);
    beat(); idle(8); beat(); idle(20);
    // toggles that must not be accepted
    step(0, 1, 1, 0); idle(5);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(0, 1, 0, 1); idle(5);
    // reset and disable mid-gate
    set_p(3, 2, 10);
    beat(); idle(5); step(1, 1, 0, 0); idle(5);
    beat(); idle(4); step(0, 0, 0, 0); step(0, 0, 0, 0); idle(5);
    // back-to-back beats with zero refractory wrap the beat counter
    set_p(0, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 260; i++) beat();
    idle(5);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0)
        set_p($urandom_range(0, 30), $urandom_range(0, 10), $urandom_range(0, 12));
      step($urandom_range(0, 999) == 0, $urandom_range(0, 49) != 0,
           (i < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0),
           $urandom_range(0, 3) != 0);
    end
    idle(6);
    @(negedge clk);
    #1;
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending strobes expected 0", ev_q.size());
    end
    checks++;
    if (beat_count !== 8'(m_bc)) begin
      errors++;
      $display("FAIL final_count: got %0d expected %0d", beat_count, m_bc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecg_gate_timer.md
ECG_GATE_TIMER -- requirements
Module: ecg_gate_timer

Interface
REQ-001 Parameter CNT_W, default 16: width of every interval, refractory, delay and width quantity.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  block active when 1; 0 = soft clear.
REQ-005 edge_state  input  1  level output of the upstream edge detector.
REQ-006 edge_toggle  input  1  toggles once per detected edge from the upstream edge detector.
REQ-007 refractory  input  CNT_W  minimum cycles from one accepted beat to the next.
REQ-008 gate_delay  input  CNT_W  cycles from accepted beat to gate rise.
REQ-009 gate_width  input  CNT_W  gate high duration in cycles.
REQ-010 gate  output  1  camera/laser gating pulse.
REQ-011 rr_interval  output  CNT_W  cycles between the last two accepted beats.
REQ-012 rr_valid  output  1  one-cycle strobe; rr_interval updated this cycle.
REQ-013 missed_beat  output  1  one-cycle strobe on interval timeout.
REQ-014 beat_count  output  8  accepted beats, wraps 255->0.

Function
REQ-015 The block SHALL register edge_toggle into tog_q each cycle; raw beat = (edge_toggle != tog_q) & edge_state, evaluated in the same cycle.
REQ-016 Acceptance FSM SHALL have states IDLE, REFRACT, ARMED.
REQ-017 IDLE: raw beat -> accepted, go REFRACT, no rr_valid.
REQ-018 REFRACT: raw beats ignored; go ARMED in the cycle after ivl_cnt >= refractory (refractory=0 -> ARMED the cycle after the beat).
REQ-019 ARMED: raw beat -> accepted, rr_interval <= ivl_cnt, rr_valid=1 for one cycle, go REFRACT.
REQ-020 ivl_cnt SHALL load 1 on an accepted beat, else increment saturating at all-ones, so rr_interval equals the exact cycle distance between accepted beats.
REQ-021 In REFRACT or ARMED, ivl_cnt reaching all-ones SHALL pulse missed_beat once and go IDLE; the next beat gives no rr_valid.
REQ-022 Each accepted beat SHALL increment beat_count (8-bit wrap).
REQ-023 Gate sequencer SHALL have states G_IDLE, G_DELAY, G_ON, with delay and width counters of CNT_W bits.
REQ-024 An accepted beat at cycle t SHALL start G_DELAY; gate rises at cycle t+1+gate_delay and stays high for exactly gate_width cycles.
REQ-025 gate_width=0 SHALL produce no gate pulse; the sequencer returns to G_IDLE.
REQ-026 An accepted beat while in G_DELAY or G_ON SHALL restart the sequence (retrigger): gate drops the next cycle unless gate_delay=0.
REQ-027 refractory, gate_delay and gate_width SHALL be sampled at each accepted beat; changes mid-sequence take effect at the next beat.
REQ-028 enable=0 SHALL force IDLE and G_IDLE, gate=0, and strobes 0, and SHALL hold rr_interval and beat_count; tog_q keeps tracking so a stale toggle is never seen as a beat on re-enable.
REQ-029 A simultaneous timeout and raw beat in ARMED SHALL be treated as an accepted beat: rr_valid with rr_interval = all-ones, no missed_beat.

Reset
REQ-030 rst SHALL set gate, rr_valid, missed_beat to 0; rr_interval, beat_count, ivl_cnt to 0; tog_q to edge_toggle; FSMs to IDLE and G_IDLE; rst has priority over enable.
REQ-031 rst asserted mid-pulse SHALL drop gate in the next cycle; no output strobe during or in the cycle after reset.

Verification
REQ-032 refractory=10, delay=3, width=4; beats at cycles 100, 300 -> gate high cycles 104-107 and 304-307; rr_valid at 300 with rr_interval=200; beat_count=2.
REQ-033 refractory=50; beats at 100, 130, 200 -> beat at 130 ignored; rr_interval=100 at 200; beat_count=2.
REQ-034 With CNT_W=8, beat at 10 and no further beat -> missed_beat pulse once about 255 cycles later, FSM IDLE; next beat gives no rr_valid.
REQ-035 delay=0, width=20, refractory=5; beats at 0, 10 -> gate high 1-10, retriggered high 11-30 continuously.
REQ-036 Toggle with edge_state=0, and toggle during enable=0 -> no accepted beat, gate stays 0; rst at mid-gate -> gate 0 next cycle and all outputs at reset values.
